simple_fsm_run_detect: RTL and testbench



---
 rtl/simple_fsm_pkg.sv | 21 ++
 rtl/simple_fsm_run_chan.sv | 105 ++++++++++
 rtl/simple_fsm_run_detect.sv | 59 +++++
 tb/tb_simple_fsm_run_detect.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/simple_fsm_pkg.sv
// Shared definitions for the run-length detector: state encodings and
// the legal parameter envelope.
package simple_fsm_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_COUNT  = 2'b01;
    localparam logic [1:0] ST_DETECT = 2'b10;
    localparam logic [1:0] ST_HOLD   = 2'b11;

    localparam int RUN_LEN_MIN  = 1;
    localparam int RUN_LEN_MAX  = 255;
    localparam int CHANNELS_MIN = 1;
    localparam int CHANNELS_MAX = 32;

    function automatic bit params_legal(input int run_len, input int channels, input int pulse_mode);
        return (run_len >= RUN_LEN_MIN) && (run_len <= RUN_LEN_MAX) &&
               (channels >= CHANNELS_MIN) && (channels <= CHANNELS_MAX) &&
               ((pulse_mode == 0) || (pulse_mode == 1));
    endfunction

endpackage

// File: rtl/simple_fsm_run_chan.sv
// One detector channel: Moore FSM plus saturating run counter.
// z is decoded from the registered state only.
import simple_fsm_pkg::*;

module simple_fsm_run_chan #(
    parameter int  RUN_LEN    = 2,
    parameter int  PULSE_MODE = 0,
    localparam int CW         = $clog2(RUN_LEN + 1)
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          clr,
    input  logic          en,
    input  logic          w,
    output logic          z,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RUN_LEN);

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next-state and counter logic; disabled cycles leave everything untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (w) begin
                        state_d = (RUN_LEN == 1) ? ST_DETECT : ST_COUNT;
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end
                ST_COUNT: begin
                    if (!w) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if ((cnt_q + CNT_ONE) == CNT_FULL) begin
                        state_d = ST_DETECT;
                        cnt_d   = CNT_FULL;
                    end else begin
                        state_d = ST_COUNT;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
                ST_DETECT: begin
                    if (!w) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else if (PULSE_MODE != 0) begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_FULL;
                    end else begin
                        state_d = ST_DETECT;
                        cnt_d   = CNT_FULL;
                    end
                end
                ST_HOLD: begin
                    // HOLD has no meaning in level mode, so treat it as a stray encoding there
                    if (!w || (PULSE_MODE == 0)) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = CNT_FULL;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
            cnt_d   = cnt_q;
        end
    end

    // State and counter registers.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign z   = (state_q == ST_DETECT);
    assign cnt = cnt_q;

endmodule

// File: rtl/simple_fsm_run_detect.sv
// Multi-channel run detector: CHANNELS independent run-length FSMs and a
// registered OR of their detect outputs.
import simple_fsm_pkg::*;

module simple_fsm_run_detect #(
    parameter int  RUN_LEN    = 2,
    parameter int  CHANNELS   = 1,
    parameter int  PULSE_MODE = 0,
    localparam int CW         = $clog2(RUN_LEN + 1)
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   clr,
    input  logic                   en,
    input  logic [CHANNELS-1:0]    w,
    output logic [CHANNELS-1:0]    z,
    output logic                   any_z,
    output logic [CHANNELS*CW-1:0] run_cnt
);

    if (!params_legal(RUN_LEN, CHANNELS, PULSE_MODE)) begin : g_bad_params
        $error("simple_fsm_run_detect: parameter out of range");
    end

    logic any_z_q;
    logic any_z_d;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        simple_fsm_run_chan #(
            .RUN_LEN    (RUN_LEN),
            .PULSE_MODE (PULSE_MODE)
        ) u_chan (
            .Clock  (Clock),
            .Resetn (Resetn),
            .clr    (clr),
            .en     (en),
            .w      (w[i]),
            .z      (z[i]),
            .cnt    (run_cnt[i*CW +: CW])
        );
    end

    // Summary detect is the OR of the channel outputs, one cycle behind them.
    always_comb begin
        any_z_d = |z;
    end

    // Summary detect register.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            any_z_q <= 1'b0;
        end else begin
            any_z_q <= any_z_d;
        end
    end

    assign any_z = any_z_q;

endmodule

// File: tb/tb_simple_fsm_run_detect.sv
// Directed bench for simple_fsm_run_detect across several parameter corners.
module tb_simple_fsm_run_detect;

    logic Clock;
    logic Resetn;

    // defaults (2,1,0)
    logic       d_clr, d_en, d_w, d_z, d_any;
    logic [1:0] d_cnt;
    // RUN_LEN=4 pulse
    logic       p_clr, p_en, p_w, p_z, p_any;
    logic [2:0] p_cnt;
    // RUN_LEN=3, 3 channels
    logic       c_clr, c_en, c_any;
    logic [2:0] c_w, c_z;
    logic [5:0] c_cnt;
    // RUN_LEN=1 level and pulse
    logic       l_clr, l_en, l_w, l_z, l_any, l_cnt;
    logic       q_clr, q_en, q_w, q_z, q_any, q_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    simple_fsm_run_detect #(.RUN_LEN(2), .CHANNELS(1), .PULSE_MODE(0)) u_def (
        .Clock(Clock), .Resetn(Resetn), .clr(d_clr), .en(d_en), .w(d_w),
        .z(d_z), .any_z(d_any), .run_cnt(d_cnt));
    simple_fsm_run_detect #(.RUN_LEN(4), .CHANNELS(1), .PULSE_MODE(1)) u_p4 (
        .Clock(Clock), .Resetn(Resetn), .clr(p_clr), .en(p_en), .w(p_w),
        .z(p_z), .any_z(p_any), .run_cnt(p_cnt));
    simple_fsm_run_detect #(.RUN_LEN(3), .CHANNELS(3), .PULSE_MODE(0)) u_c3 (
        .Clock(Clock), .Resetn(Resetn), .clr(c_clr), .en(c_en), .w(c_w),
        .z(c_z), .any_z(c_any), .run_cnt(c_cnt));
    simple_fsm_run_detect #(.RUN_LEN(1), .CHANNELS(1), .PULSE_MODE(0)) u_r1l (
        .Clock(Clock), .Resetn(Resetn), .clr(l_clr), .en(l_en), .w(l_w),
        .z(l_z), .any_z(l_any), .run_cnt(l_cnt));
    simple_fsm_run_detect #(.RUN_LEN(1), .CHANNELS(1), .PULSE_MODE(1)) u_r1p (
        .Clock(Clock), .Resetn(Resetn), .clr(q_clr), .en(q_en), .w(q_w),
        .z(q_z), .any_z(q_any), .run_cnt(q_cnt));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // hand-computed tables
    int def_w[7]   = '{0, 1, 1, 1, 0, 1, 0};
    int def_z[7]   = '{0, 0, 1, 1, 0, 0, 0};
    int def_c[7]   = '{0, 1, 2, 2, 0, 1, 0};
    int p4_w[12]   = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    int p4_z[12]   = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int p4_c[12]   = '{1, 2, 3, 4, 4, 4, 4, 0, 1, 2, 3, 4};
    int c3_w1[8]   = '{1, 1, 0, 1, 1, 0, 1, 1};
    int c3_z0[8]   = '{0, 0, 1, 1, 1, 1, 1, 1};
    int c3_c0[8]   = '{1, 2, 3, 3, 3, 3, 3, 3};
    int c3_c1[8]   = '{1, 2, 0, 1, 2, 0, 1, 2};
    int c3_any[8]  = '{0, 0, 0, 1, 1, 1, 1, 1};
    int gap_en[5]  = '{1, 0, 0, 1, 1};
    int gap_z[5]   = '{0, 0, 0, 0, 1};
    int gap_c[5]   = '{1, 1, 1, 2, 3};
    int r1l_w[3]   = '{1, 0, 1};
    int r1l_z[3]   = '{1, 0, 1};
    int r1p_z[3]   = '{1, 0, 0};

    initial begin
        int prev_z;
        Resetn = 1'b0;
        {d_clr, d_en, d_w} = 3'b000;
        {p_clr, p_en, p_w} = 3'b000;
        {c_clr, c_en} = 2'b00;
        c_w = 3'b000;
        {l_clr, l_en, l_w} = 3'b000;
        {q_clr, q_en, q_w} = 3'b000;
        #12;
        check_eq("rst_def_z", 32'(d_z), 32'd0);
        check_eq("rst_def_any", 32'(d_any), 32'd0);
        check_eq("rst_def_cnt", 32'(d_cnt), 32'd0);
        check_eq("rst_c3_cnt", 32'(c_cnt), 32'd0);
        Resetn = 1'b1;
        #4;

        // defaults: original two-in-a-row behaviour
        d_en = 1'b1;
        prev_z = 0;
        for (int i = 0; i < 7; i++) begin
            d_w = def_w[i][0];
            tick();
            check_eq($sformatf("def_z[%0d]", i), 32'(d_z), 32'(def_z[i]));
            check_eq($sformatf("def_cnt[%0d]", i), 32'(d_cnt), 32'(def_c[i]));
            check_eq($sformatf("def_any[%0d]", i), 32'(d_any), 32'(prev_z));
            prev_z = def_z[i];
        end
        d_en = 1'b0;

        // RUN_LEN=4 pulse mode
        p_en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            p_w = p4_w[i][0];
            tick();
            check_eq($sformatf("p4_z[%0d]", i), 32'(p_z), 32'(p4_z[i]));
            check_eq($sformatf("p4_cnt[%0d]", i), 32'(p_cnt), 32'(p4_c[i]));
        end
        p_en = 1'b0;

        // three channels, RUN_LEN=3
        c_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c_w = {1'b0, c3_w1[i][0], 1'b1};
            tick();
            check_eq($sformatf("c3_z[%0d]", i), 32'(c_z), 32'(c3_z0[i]));
            check_eq($sformatf("c3_cnt0[%0d]", i), 32'(c_cnt[1:0]), 32'(c3_c0[i]));
            check_eq($sformatf("c3_cnt1[%0d]", i), 32'(c_cnt[3:2]), 32'(c3_c1[i]));
            check_eq($sformatf("c3_cnt2[%0d]", i), 32'(c_cnt[5:4]), 32'd0);
            check_eq($sformatf("c3_any[%0d]", i), 32'(c_any), 32'(c3_any[i]));
        end

        // clr while enabled returns to IDLE
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        check_eq("c3_clr_z", 32'(c_z), 32'd0);
        check_eq("c3_clr_cnt", 32'(c_cnt), 32'd0);

        // disabled cycles are invisible to the run
        c_w = 3'b001;
        for (int i = 0; i < 5; i++) begin
            c_en = gap_en[i][0];
            tick();
            check_eq($sformatf("gap_z[%0d]", i), 32'(c_z[0]), 32'(gap_z[i]));
            check_eq($sformatf("gap_cnt[%0d]", i), 32'(c_cnt[1:0]), 32'(gap_c[i]));
        end
        // en=0 in DETECT keeps z, then clr with en=0 wins
        c_en = 1'b0;
        tick();
        check_eq("gap_hold_z", 32'(c_z[0]), 32'd1);
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        check_eq("clr_en0_z", 32'(c_z[0]), 32'd0);
        check_eq("clr_en0_cnt", 32'(c_cnt[1:0]), 32'd0);

        // build up state, then reset asynchronously mid-COUNT
        c_en = 1'b1;
        c_w  = 3'b001;
        d_en = 1'b1;
        d_w  = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        d_w = 1'b1;
        tick();
        check_eq("pre_rst_def_cnt", 32'(d_cnt), 32'd1);
        check_eq("pre_rst_c3_z", 32'(c_z[0]), 32'd1);
        check_eq("pre_rst_c3_any", 32'(c_any), 32'd1);
        #3;
        Resetn = 1'b0;
        #1;
        check_eq("arst_def_z", 32'(d_z), 32'd0);
        check_eq("arst_def_cnt", 32'(d_cnt), 32'd0);
        check_eq("arst_c3_z", 32'(c_z), 32'd0);
        check_eq("arst_c3_any", 32'(c_any), 32'd0);
        check_eq("arst_c3_cnt", 32'(c_cnt), 32'd0);
        #2;
        Resetn = 1'b1;
        c_en = 1'b0;
        tick();
        check_eq("post_rst_z1", 32'(d_z), 32'd0);
        check_eq("post_rst_cnt1", 32'(d_cnt), 32'd1);
        tick();
        check_eq("post_rst_z2", 32'(d_z), 32'd1);
        d_en = 1'b0;

        // RUN_LEN=1, level and pulse
        l_en = 1'b1;
        q_en = 1'b1;
        q_w  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            l_w = r1l_w[i][0];
            tick();
            check_eq($sformatf("r1l_z[%0d]", i), 32'(l_z), 32'(r1l_z[i]));
            check_eq($sformatf("r1l_cnt[%0d]", i), 32'(l_cnt), 32'(r1l_z[i]));
            check_eq($sformatf("r1p_z[%0d]", i), 32'(q_z), 32'(r1p_z[i]));
            check_eq($sformatf("r1p_cnt[%0d]", i), 32'(q_cnt), 32'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
